lcd_text_ctrl: RTL

- Parametrised successor to the team's fixed 2x16 LCD_display driver.
- Drives an HD44780-compatible character LCD in 8-bit write-only mode: ROWS x COLS text (1-4 rows, 1-40 columns).
- Runs the power-up/init command sequence itself, then rewrites the full text buffer on request.
- Adds a start/busy/done handshake, a one-deep pending request, and parametrised bus timing.
- Sits between the application FSM (user/admin message generator) and the LCD pins.

---
 rtl/lcd_text_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: HD44780-compatible character LCD driver, 8-bit write-only mode,
// ROWS x COLS text. Runs the power-up/init sequence, then rewrites the whole text
// buffer on each start request (one-deep pending request while busy).
// Optional feature macro: LCD_AUTO_REFRESH_EN -- when defined, a difference between
// text_in and the latched buffer while idle is treated as a start request.
// All timing parameters must be >= 1.
module lcd_text_ctrl #(
  parameter int ROWS           = 2,
  parameter int COLS           = 16,
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_PULSE_CYC   = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS*COLS*8-1:0] text_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rs,
  output logic                   rw,
  output logic                   en,
  output logic [7:0]             data
);

  localparam int MAX_CYC = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLEAR_WAIT_CYC - 1);
  localparam logic [1:0]       ROW_LAST   = 2'(ROWS - 1);
  localparam logic [5:0]       COL_LAST   = 6'(COLS - 1);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_ADDR, S_CHAR, S_DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  // HD44780 init: 8-bit/2-line/5x8, display on, clear, entry mode increment
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // DDRAM start address of each display row
  function automatic logic [6:0] row_base(input logic [1:0] row);
    case (row)
      2'd0:    row_base = 7'h00;
      2'd1:    row_base = 7'h40;
      2'd2:    row_base = 7'h14;
      default: row_base = 7'h54;
    endcase
  endfunction

  state_t                 r_state, w_state_nxt;
  phase_t                 r_ph, w_ph_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [1:0]             r_init_idx, w_init_idx_nxt;
  logic [1:0]             r_row, w_row_nxt;
  logic [5:0]             r_col, w_col_nxt;
  logic                   r_pend, w_pend_nxt;
  logic [ROWS*COLS*8-1:0] r_buf, w_buf_nxt;
  logic                   r_en, r_busy, r_done;
  logic                   w_go, w_begin, w_rs;
  logic [7:0]             w_data;
  logic [CNT_W-1:0]       w_wait_last;
  logic [7:0]             w_bytes [4][64];

  // Byte view of the latched buffer, padded so row/col registers index it exactly
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < 64; gc++) begin : g_col
      if (gr < ROWS && gc < COLS) begin : g_used
        assign w_bytes[gr][gc] = r_buf[(gr*COLS + gc)*8 +: 8];
      end else begin : g_pad
        assign w_bytes[gr][gc] = 8'h20;
      end
    end
  end

`ifdef LCD_AUTO_REFRESH_EN
  assign w_go = start | r_pend | (text_in != r_buf);
`else
  assign w_go = start | r_pend;
`endif

  // Bus content of the transfer in progress, held through setup, pulse and wait
  always_comb begin
    w_rs   = 1'b0;
    w_data = 8'h00;
    case (r_state)
      S_INIT: w_data = init_cmd(r_init_idx);
      S_ADDR: w_data = {1'b1, row_base(r_row)};
      S_CHAR: begin
        w_rs   = 1'b1;
        w_data = w_bytes[r_row][r_col];
      end
      default: ;
    endcase
    w_wait_last = (!w_rs && w_data == 8'h01) ? CLR_LAST : CMD_LAST;
  end

  // Next-state logic: FSM sequencing, transfer phases, request handling
  always_comb begin
    w_state_nxt    = r_state;
    w_ph_nxt       = r_ph;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_init_idx_nxt = r_init_idx;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_pend_nxt     = r_pend | start;
    w_buf_nxt      = r_buf;
    w_begin        = 1'b0;
    case (r_state)
      S_PWR: begin
        if (r_cnt == PWR_LAST) begin
          w_state_nxt    = S_INIT;
          w_ph_nxt       = PH_SETUP;
          w_cnt_nxt      = '0;
          w_init_idx_nxt = 2'd0;
        end
      end
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_begin   = w_go;
      end
      S_INIT, S_ADDR, S_CHAR: begin
        case (r_ph)
          PH_SETUP: if (r_cnt == SETUP_LAST) begin
            w_ph_nxt  = PH_PULSE;
            w_cnt_nxt = '0;
          end
          PH_PULSE: if (r_cnt == PULSE_LAST) begin
            w_ph_nxt  = PH_WAIT;
            w_cnt_nxt = '0;
          end
          default: if (r_cnt == w_wait_last) begin
            w_ph_nxt  = PH_SETUP;
            w_cnt_nxt = '0;
            if (r_state == S_INIT) begin
              if (r_init_idx == 2'd3) begin
                w_state_nxt = S_IDLE;
                w_begin     = w_go;
              end else begin
                w_init_idx_nxt = r_init_idx + 1'b1;
              end
            end else if (r_state == S_ADDR) begin
              w_state_nxt = S_CHAR;
              w_col_nxt   = '0;
            end else if (r_col != COL_LAST) begin
              w_col_nxt = r_col + 1'b1;
            end else if (r_row != ROW_LAST) begin
              w_state_nxt = S_ADDR;
              w_row_nxt   = r_row + 1'b1;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        endcase
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
        w_begin     = w_go;
      end
    endcase
    // A refresh starts on the same edge the controller would otherwise go idle
    if (w_begin) begin
      w_state_nxt = S_ADDR;
      w_ph_nxt    = PH_SETUP;
      w_cnt_nxt   = '0;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
      w_pend_nxt  = 1'b0;
      w_buf_nxt   = text_in;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_PWR;
      r_ph       <= PH_SETUP;
      r_cnt      <= '0;
      r_init_idx <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_pend     <= 1'b0;
      r_buf      <= {(ROWS*COLS){8'h20}};
      r_en       <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ph       <= w_ph_nxt;
      r_cnt      <= w_cnt_nxt;
      r_init_idx <= w_init_idx_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_pend     <= w_pend_nxt;
      r_buf      <= w_buf_nxt;
      r_en       <= (w_ph_nxt == PH_PULSE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign rs   = w_rs;
  assign data = w_data;
  assign rw   = 1'b0;
  assign en   = r_en;
  assign busy = r_busy;
  assign done = r_done;

endmodule
